// File: rtl/axi_rd_beat_collector_if.sv
// Command, AXI R-channel and output-stream signals of the read beat collector.
// slave is the collector's view; master is the view of whatever drives it.
interface axi_rd_beat_collector_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [7:0]              cmd_len;
  logic [ID_MAX_WIDTH-1:0] cmd_id;

  logic                    rvalid;
  logic                    rready;
  logic [ID_MAX_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    ruser;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;

  modport slave (
    input  cmd_valid, cmd_len, cmd_id,
    input  rvalid, rid, rdata, rresp, rlast, ruser,
    input  out_ready,
    output cmd_ready, rready, out_valid, out_data, out_last
  );

  modport master (
    output cmd_valid, cmd_len, cmd_id,
    output rvalid, rid, rdata, rresp, rlast, ruser,
    output out_ready,
    input  cmd_ready, rready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/axi_rd_beat_collector.sv
// AXI R-channel burst collector: checks beats against the command, buffers them, streams them out.
// Latency: accepted beat visible on out one cycle later; rready drops only on a registered-full FIFO.

module axi_rd_beat_collector_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             not_empty,
  output logic [WIDTH-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && not_empty;
  assign head_dat  = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module axi_rd_beat_collector #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  axi_rd_beat_collector_if.slave   bus,
  output logic                     burst_done,
  output logic                     err_resp,
  output logic                     err_id,
  output logic                     err_last,
  input  logic                     err_clr
);
  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              len;
  logic [ID_MAX_WIDTH-1:0] id;
  logic [7:0]              beat_cnt;

  logic                    beat_acc;
  logic                    is_last;
  logic                    fifo_full;
  logic                    fifo_vld;
  logic [DATA_WIDTH:0]     fifo_head;
  logic                    set_resp;
  logic                    set_id;
  logic                    set_last;
  logic                    unused_ruser;

  assign unused_ruser = bus.ruser;
  assign is_last      = (beat_cnt == len);
  assign beat_acc     = bus.rvalid && bus.rready;

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.rready    = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = RECV;
      end
      RECV: begin
        bus.rready = !fifo_full;
        if (beat_acc && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      id       <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        len      <= bus.cmd_len;
        id       <= bus.cmd_id;
        beat_cnt <= '0;
      end else if (beat_acc && !is_last) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign set_resp = beat_acc && (bus.rresp != 2'b00);
  assign set_id   = beat_acc && (bus.rid != id);
  assign set_last = beat_acc && (bus.rlast != is_last);

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_done <= 1'b0;
      err_resp   <= 1'b0;
      err_id     <= 1'b0;
      err_last   <= 1'b0;
    end else begin
      burst_done <= beat_acc && is_last;
      err_resp   <= set_resp || (err_resp && !err_clr);
      err_id     <= set_id   || (err_id   && !err_clr);
      err_last   <= set_last || (err_last && !err_clr);
    end
  end

  axi_rd_beat_collector_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (beat_acc),
    .push_dat  ({bus.rdata, is_last}),
    .pop       (bus.out_ready),
    .full      (fifo_full),
    .not_empty (fifo_vld),
    .head_dat  (fifo_head)
  );

  assign bus.out_valid = fifo_vld;
  assign bus.out_data  = fifo_head[DATA_WIDTH:1];
  assign bus.out_last  = fifo_head[0];
endmodule

// File: tb/tb_axi_rd_beat_collector.sv
// Directed and randomized bench for axi_rd_beat_collector against a queue-based reference model.
module tb_axi_rd_beat_collector;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic burst_done, err_resp, err_id, err_last, err_clr;

  axi_rd_beat_collector_if #(.DATA_WIDTH(32), .ID_MAX_WIDTH(16)) bus ();

  axi_rd_beat_collector #(.DATA_WIDTH(32), .ID_MAX_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .burst_done (burst_done),
    .err_resp   (err_resp),
    .err_id     (err_id),
    .err_last   (err_last),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } ent_t;

  int errors = 0;
  int checks = 0;

  // reference model state
  ent_t        q[$];
  bit          busy;
  int          cur_len;
  logic [15:0] cur_id;
  int          beat;
  bit          m_resp, m_id, m_last, m_done;

  // per-beat stimulus of the burst being sent
  logic [31:0] b_data [256];
  logic [15:0] b_id   [256];
  logic [1:0]  b_resp [256];
  logic        b_last [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy = 0; beat = 0; cur_len = 0; cur_id = '0;
    m_resp = 0; m_id = 0; m_last = 0; m_done = 0;
  endtask

  // Check registered outputs, then advance one clock and update the model.
  task automatic tick(output bit acc);
    bit   pop, cmdhs, rst_now, clr, s_resp, s_id, s_last;
    ent_t e;
    chk("cmd_ready", bus.cmd_ready, !busy);
    chk("rready", bus.rready, busy && (q.size() < DEPTH));
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("burst_done", burst_done, m_done);
    chk("err_resp", err_resp, m_resp);
    chk("err_id", err_id, m_id);
    chk("err_last", err_last, m_last);
    pop = bus.out_valid && bus.out_ready && (q.size() != 0);
    if (pop) begin
      chk("out_data", bus.out_data, q[0].d);
      chk("out_last", bus.out_last, q[0].l);
    end
    acc     = bus.rvalid && bus.rready && busy;
    cmdhs   = bus.cmd_valid && bus.cmd_ready && !busy;
    rst_now = rst;
    clr     = err_clr;
    s_resp  = acc && (bus.rresp != 2'b00);
    s_id    = acc && (bus.rid != cur_id);
    s_last  = acc && (bus.rlast != (beat == cur_len));
    e.d     = bus.rdata;
    e.l     = (beat == cur_len);
    @(posedge clk);
    if (rst_now) begin
      model_reset();
      acc = 0;
    end else begin
      m_done = acc && (beat == cur_len);
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (beat == cur_len) busy = 0;
        else beat++;
      end else if (cmdhs) begin
        busy = 1; cur_len = bus.cmd_len; cur_id = bus.cmd_id; beat = 0;
      end
      m_resp = s_resp || (m_resp && !clr);
      m_id   = s_id   || (m_id   && !clr);
      m_last = s_last || (m_last && !clr);
    end
    @(negedge clk);
  endtask

  task automatic setup(input int len, input logic [15:0] id);
    for (int i = 0; i <= len; i++) begin
      b_data[i] = $urandom;
      b_id[i]   = id;
      b_resp[i] = 2'b00;
      b_last[i] = (i == len);
    end
  endtask

  task automatic send_cmd(input int len, input logic [15:0] id);
    bit a;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'(len);
    bus.cmd_id    = id;
    for (int k = 0; k < 10 && !bus.cmd_ready; k++) tick(a);
    tick(a);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input int i, input bit v);
    bus.rvalid = v;
    bus.rdata  = b_data[i];
    bus.rid    = b_id[i];
    bus.rresp  = b_resp[i];
    bus.rlast  = b_last[i];
    bus.ruser  = 1'($urandom);
  endtask

  task automatic drain();
    bit a;
    bus.rvalid    = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) tick(a);
    tick(a);
    chk("drained_out_valid", bus.out_valid, 1'b0);
  endtask

  // rvp/orp: percent chance of rvalid/out_ready per cycle; out_ready forced low for the first hold cycles.
  task automatic run_burst(input int len, input logic [15:0] id, input int rvp, input int orp,
                           input int hold, input bit want_hi);
    bit a;
    int i = 0;
    int cyc = 0;
    send_cmd(len, id);
    while (busy && cyc < 3000) begin
      if (hold > 0 && cyc == hold) begin
        chk("bp_accepted", 64'(i), 64'((len + 1 < DEPTH) ? len + 1 : DEPTH));
        chk("bp_rready_low", bus.rready, 1'b0);
      end
      if (want_hi) chk("stream_rready_high", bus.rready, 1'b1);
      drive_beat(i, $urandom_range(99) < rvp);
      bus.out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < orp);
      tick(a);
      if (a) i++;
      cyc++;
    end
    chk("burst_beats", 64'(i), 64'(len + 1));
    drain();
  endtask

  initial begin
    bit a;
    int n;
    logic [15:0] rid_v;
    model_reset();
    rst = 1'b1; err_clr = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_id = '0;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 1'b0; bus.ruser = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick(a);

    // single-beat burst
    setup(0, 16'd5);
    b_data[0] = 32'hA5A5A5A5;
    run_burst(0, 16'd5, 100, 100, 0, 0);
    chk("single_no_err", {err_resp, err_id, err_last}, 3'b000);

    // 16-beat streaming, data 0..15
    setup(15, 16'd1);
    for (int i = 0; i < 16; i++) b_data[i] = 32'(i);
    run_burst(15, 16'd1, 100, 100, 0, 1);

    // backpressure: FIFO fills, then releases
    setup(15, 16'd7);
    run_burst(15, 16'd7, 100, 100, 20, 0);

    // error detection, then clear
    setup(3, 16'd2);
    b_resp[1] = 2'b10; b_id[2] = 16'd3; b_last[2] = 1'b1; b_last[3] = 1'b1;
    run_burst(3, 16'd2, 100, 100, 0, 0);
    chk("err_set", {err_resp, err_id, err_last}, 3'b111);
    err_clr = 1'b1; tick(a); err_clr = 1'b0; tick(a);
    chk("err_cleared", {err_resp, err_id, err_last}, 3'b000);

    // missing rlast
    setup(1, 16'd4);
    b_last[1] = 1'b0;
    run_burst(1, 16'd4, 100, 100, 0, 0);
    chk("missing_rlast_err", err_last, 1'b1);
    err_clr = 1'b1; tick(a); err_clr = 1'b0;

    // reset after 3 of 8 beats, with an error pending
    setup(7, 16'd9);
    b_resp[0] = 2'b01;
    send_cmd(7, 16'd9);
    bus.out_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 50 && n < 3; k++) begin
      drive_beat(n, 1'b1);
      tick(a);
      if (a) n++;
    end
    bus.rvalid = 1'b0;
    chk("pre_rst_err", err_resp, 1'b1);
    rst = 1'b1; tick(a); rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rready", bus.rready, 1'b0);
    chk("rst_errs", {err_resp, err_id, err_last}, 3'b000);
    setup(7, 16'd9);
    run_burst(7, 16'd9, 100, 100, 0, 0);

    // randomized bursts with sporadic errors
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, 20);
      rid_v = 16'($urandom);
      setup(n, rid_v);
      for (int i = 0; i <= n; i++) begin
        if ($urandom_range(99) < 8) b_resp[i] = 2'($urandom_range(1, 3));
        if ($urandom_range(99) < 8) b_id[i]   = rid_v ^ 16'h0100;
        if ($urandom_range(99) < 8) b_last[i] = !b_last[i];
      end
      run_burst(n, rid_v, $urandom_range(40, 100), $urandom_range(20, 100), 0, 0);
      err_clr = 1'b1; tick(a); err_clr = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
